// File: rtl/raster_pkg.sv
// raster_pkg: shared types, FSM state encoding and edge-function helper for the
// triangle rasterizer.
package raster_pkg;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned EDGE_W  = 2 * COORD_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SCAN,
        DONE
    } raster_state_t;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [EDGE_W-1:0]  edge_t;

    // E(x,y) for edge a->b; positive on one side, negative on the other, zero on the line.
    function automatic edge_t edge_fn(input coord_t xa, input coord_t ya,
                                      input coord_t xb, input coord_t yb,
                                      input coord_t x,  input coord_t y);
        edge_t px, py, ex, ey;
        px = edge_t'(x)  - edge_t'(xa);
        py = edge_t'(y)  - edge_t'(ya);
        ex = edge_t'(xb) - edge_t'(xa);
        ey = edge_t'(yb) - edge_t'(ya);
        return (px * ey) - (py * ex);
    endfunction

endpackage

// File: rtl/triangle_rasterizer_if.sv
// triangle_rasterizer_if: pixel-write bus between the rasterizer (master) and the
// framebuffer/depth-buffer display block (slave).
interface triangle_rasterizer_if #(
    parameter int ADDR_W = 15,
    parameter int FB_W   = 4,
    parameter int DB_W   = 12
);
    logic              i_display_ready;
    logic [ADDR_W-1:0] o_pixel_write_addr;
    logic [FB_W-1:0]   o_fb_data;
    logic [DB_W-1:0]   o_db_data;
    logic              o_pixel_write_valid;

    modport master (
        input  i_display_ready,
        output o_pixel_write_addr, o_fb_data, o_db_data, o_pixel_write_valid
    );

    modport slave (
        output i_display_ready,
        input  o_pixel_write_addr, o_fb_data, o_db_data, o_pixel_write_valid
    );
endinterface

// File: rtl/edge_stepper.sv
// edge_stepper: holds one edge function's current and row-start values and walks
// them across the bounding box in raster order.
module edge_stepper
    import raster_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  step_x,
    input  logic  step_y,
    input  edge_t load_val,
    input  edge_t load_dx,
    input  edge_t load_dy,
    output edge_t value
);
    edge_t row_q, dx_q, dy_q;

    // Neither step asserted holds the value, which is how a display stall freezes the walk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            row_q <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
        end else if (load) begin
            value <= load_val;
            row_q <= load_val;
            dx_q  <= load_dx;
            dy_q  <= load_dy;
        end else if (step_y) begin
            value <= row_q + dy_q;
            row_q <= row_q + dy_q;
        end else if (step_x) begin
            value <= value + dx_q;
        end
    end
endmodule

// File: rtl/triangle_rasterizer.sv
// triangle_rasterizer: scan-converts one flat-shaded triangle into pixel writes.
// Define RASTER_BACKFACE_CULL_EN to discard triangles with negative signed area.
module triangle_rasterizer
    import raster_pkg::*;
#(
    parameter int DISPLAY_WIDTH       = 160,
    parameter int DISPLAY_HEIGHT      = 120,
    parameter int DISPLAY_COORD_WIDTH = COORD_W,
    parameter int FB_DATA_WIDTH       = 4,
    parameter int DB_DATA_WIDTH       = 12
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_start,
    input  logic signed [DISPLAY_COORD_WIDTH-1:0] i_x0,
    input  logic signed [DISPLAY_COORD_WIDTH-1:0] i_y0,
    input  logic signed [DISPLAY_COORD_WIDTH-1:0] i_x1,
    input  logic signed [DISPLAY_COORD_WIDTH-1:0] i_y1,
    input  logic signed [DISPLAY_COORD_WIDTH-1:0] i_x2,
    input  logic signed [DISPLAY_COORD_WIDTH-1:0] i_y2,
    input  logic [DB_DATA_WIDTH-1:0]             i_z,
    input  logic [FB_DATA_WIDTH-1:0]             i_color,
    output logic                                 o_busy,
    output logic                                 o_done,
    triangle_rasterizer_if.master                pix
);
    localparam int BUFFER_ADDR_WIDTH = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT);
    localparam coord_t ZERO  = '0;
    localparam coord_t ONE   = coord_t'(1);
    localparam coord_t X_LIM = coord_t'(DISPLAY_WIDTH - 1);
    localparam coord_t Y_LIM = coord_t'(DISPLAY_HEIGHT - 1);
    localparam logic [BUFFER_ADDR_WIDTH-1:0] ROW_STRIDE = BUFFER_ADDR_WIDTH'(DISPLAY_WIDTH);

    raster_state_t state_q, state_d;

    coord_t                       vx [3];
    coord_t                       vy [3];
    logic [DB_DATA_WIDTH-1:0]     z_q, db_q;
    logic [FB_DATA_WIDTH-1:0]     color_q, fb_q;
    logic                         setup2_q, area_neg_q;
    coord_t                       xmin_q, xmax_q, ymin_q, ymax_q, x_q, y_q;
    logic [BUFFER_ADDR_WIDTH-1:0] row_base_q, addr_q;
    logic                         valid_q, busy_q, done_q;

    edge_t  e_val [3];
    edge_t  area;
    coord_t bx_lo, bx_hi, by_lo, by_hi;
    logic   reject, covered, all_ge, all_le;
    logic   capture, latch_box, load_edges, visit, step_x, step_y;

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Area sign is resolved in the first setup cycle so empty, degenerate and culled
    // triangles all leave SETUP after one cycle.
    always_comb begin
        bx_lo  = min3(vx[0], vx[1], vx[2]);
        bx_hi  = max3(vx[0], vx[1], vx[2]);
        by_lo  = min3(vy[0], vy[1], vy[2]);
        by_hi  = max3(vy[0], vy[1], vy[2]);
        area   = edge_fn(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]);
        reject = (bx_hi < ZERO) || (bx_lo > X_LIM) || (by_hi < ZERO) || (by_lo > Y_LIM)
                 || (area == '0);
`ifdef RASTER_BACKFACE_CULL_EN
        reject = reject || area[EDGE_W-1];
`endif
    end

    always_comb begin
        all_ge = 1'b1;
        all_le = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            if (e_val[i][EDGE_W-1]) all_ge = 1'b0;
            if (!e_val[i][EDGE_W-1] && (e_val[i] != '0)) all_le = 1'b0;
        end
        covered = area_neg_q ? all_le : all_ge;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        latch_box  = 1'b0;
        load_edges = 1'b0;
        visit      = 1'b0;
        step_x     = 1'b0;
        step_y     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    capture = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (setup2_q) begin
                    load_edges = 1'b1;
                    state_d    = SCAN;
                end else if (reject) begin
                    state_d = DONE;
                end else begin
                    latch_box = 1'b1;
                end
            end
            SCAN: begin
                if (pix.i_display_ready) begin
                    visit = 1'b1;
                    if (x_q != xmax_q)      step_x  = 1'b1;
                    else if (y_q != ymax_q) step_y  = 1'b1;
                    else                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                vx[i] <= '0;
                vy[i] <= '0;
            end
            z_q        <= '0;
            color_q    <= '0;
            setup2_q   <= 1'b0;
            area_neg_q <= 1'b0;
            xmin_q     <= '0;
            xmax_q     <= '0;
            ymin_q     <= '0;
            ymax_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            fb_q       <= '0;
            db_q       <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            setup2_q <= latch_box;
            if (capture) begin
                vx[0]   <= coord_t'(i_x0);
                vy[0]   <= coord_t'(i_y0);
                vx[1]   <= coord_t'(i_x1);
                vy[1]   <= coord_t'(i_y1);
                vx[2]   <= coord_t'(i_x2);
                vy[2]   <= coord_t'(i_y2);
                z_q     <= i_z;
                color_q <= i_color;
            end
            if (latch_box) begin
                xmin_q     <= (bx_lo < ZERO)  ? ZERO  : bx_lo;
                xmax_q     <= (bx_hi > X_LIM) ? X_LIM : bx_hi;
                ymin_q     <= (by_lo < ZERO)  ? ZERO  : by_lo;
                ymax_q     <= (by_hi > Y_LIM) ? Y_LIM : by_hi;
                area_neg_q <= area[EDGE_W-1];
            end
            if (load_edges) begin
                x_q        <= xmin_q;
                y_q        <= ymin_q;
                row_base_q <= BUFFER_ADDR_WIDTH'(ymin_q) * ROW_STRIDE;
            end else if (step_y) begin
                x_q        <= xmin_q;
                y_q        <= y_q + ONE;
                row_base_q <= row_base_q + ROW_STRIDE;
            end else if (step_x) begin
                x_q <= x_q + ONE;
            end
            valid_q <= visit && covered;
            if (visit) begin
                addr_q <= row_base_q + BUFFER_ADDR_WIDTH'(x_q);
                fb_q   <= color_q;
                db_q   <= z_q;
            end
            busy_q <= (state_d != IDLE);
            done_q <= (state_q == DONE);
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_edge
        localparam int B = (i + 1) % 3;
        edge_stepper u_edge (
            .clk      (clk),
            .rst      (rst),
            .load     (load_edges),
            .step_x   (step_x),
            .step_y   (step_y),
            .load_val (edge_fn(vx[i], vy[i], vx[B], vy[B], xmin_q, ymin_q)),
            .load_dx  (edge_t'(vy[B]) - edge_t'(vy[i])),
            .load_dy  (edge_t'(vx[i]) - edge_t'(vx[B])),
            .value    (e_val[i])
        );
    end

    assign o_busy                  = busy_q;
    assign o_done                  = done_q;
    assign pix.o_pixel_write_addr  = addr_q;
    assign pix.o_fb_data           = fb_q;
    assign pix.o_db_data           = db_q;
    assign pix.o_pixel_write_valid = valid_q;
endmodule

// File: tb/tb_triangle_rasterizer.sv
// tb_triangle_rasterizer: directed triangles with hand-derived coverage regions,
// checked through an expected-pixel queue drained by an output monitor.
module tb_triangle_rasterizer;
    localparam int W  = 160;
    localparam int H  = 120;
    localparam int AW = 15;
`ifdef RASTER_BACKFACE_CULL_EN
    localparam bit CULL = 1'b1;
`else
    localparam bit CULL = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               i_start;
    logic signed [15:0] i_x0, i_y0, i_x1, i_y1, i_x2, i_y2;
    logic [11:0]        i_z;
    logic [3:0]         i_color;
    logic               o_busy, o_done;

    triangle_rasterizer_if #(.ADDR_W(AW), .FB_W(4), .DB_W(12)) pix ();

    triangle_rasterizer #(
        .DISPLAY_WIDTH       (W),
        .DISPLAY_HEIGHT      (H),
        .DISPLAY_COORD_WIDTH (16),
        .FB_DATA_WIDTH       (4),
        .DB_DATA_WIDTH       (12)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_x0    (i_x0),
        .i_y0    (i_y0),
        .i_x1    (i_x1),
        .i_y1    (i_y1),
        .i_x2    (i_x2),
        .i_y2    (i_y2),
        .i_z     (i_z),
        .i_color (i_color),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .pix     (pix)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    fb;
        logic [11:0]   db;
    } pix_t;

    pix_t        exp_q [$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_valid = 0;
    int          cyc = 0;
    int          run_id = 0;
    logic [3:0]  cur_color;
    logic [11:0] cur_z;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        pix_t e;
        if (!rst && pix.o_pixel_write_valid) begin
            n_valid++;
            check("addr_range", (pix.o_pixel_write_addr < AW'(W * H)), 1);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pixel: got addr %0d, required no pixel",
                         pix.o_pixel_write_addr);
            end else begin
                e = exp_q.pop_front();
                check("pix_addr", pix.o_pixel_write_addr, e.addr);
                check("pix_fb", pix.o_fb_data, e.fb);
                check("pix_db", pix.o_db_data, e.db);
            end
        end
    end

    // Covered region of every non-degenerate test triangle: box intersected with x+y<=lim.
    task automatic push_expect(input int xl, input int xh, input int yl, input int yh,
                               input int lim);
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                if (x + y <= lim) exp_q.push_back(pix_t'{AW'(y * W + x), cur_color, cur_z});
    endtask

    task automatic start_tri(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2);
        @(posedge clk); #1;
        i_x0 = 16'(x0); i_y0 = 16'(y0);
        i_x1 = 16'(x1); i_y1 = 16'(y1);
        i_x2 = 16'(x2); i_y2 = 16'(y2);
        i_z = cur_z; i_color = cur_color;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic run_tri(input string name, input int x0, input int y0, input int x1,
                           input int y1, input int x2, input int y2, input bit neg,
                           input int xl, input int xh, input int yl, input int yh,
                           input int lim, input int box_pix, input int exp_pix,
                           input int stall, input bit poke);
        int c0, nv0, lat;
        bit none, seen;
        run_id++;
        cur_color = 4'(run_id + 2);
        cur_z     = 12'(run_id * 211 + 7);
        none = (box_pix == 0) || (CULL && neg);
        if (none) exp_pix = 0;
        lat = none ? 2 : 3 + box_pix + stall;
        if (!none) push_expect(xl, xh, yl, yh, lim);
        nv0 = n_valid;
        start_tri(x0, y0, x1, y1, x2, y2);
        c0 = cyc;
        check({name, "_busy_rise"}, o_busy, 1);
        if (poke) begin
            @(posedge clk); #1;
            i_x0 = 16'sd50; i_y0 = 16'sd50; i_x1 = 16'sd60; i_y1 = 16'sd50;
            i_x2 = 16'sd50; i_y2 = 16'sd60; i_start = 1'b1;
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        if (stall > 0) begin
            repeat (6) @(posedge clk);
            #1;
            pix.i_display_ready = 1'b0;
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                check({name, "_stall_valid"}, pix.o_pixel_write_valid, 0);
            end
            pix.i_display_ready = 1'b1;
        end
        seen = 1'b0;
        for (int k = 0; k < 30000 && !seen; k++) begin
            @(posedge clk); #1;
            seen = o_done;
        end
        check({name, "_done_seen"}, seen, 1);
        check({name, "_done_latency"}, cyc - c0, lat);
        check({name, "_busy_at_done"}, o_busy, 0);
        check({name, "_pixel_count"}, n_valid - nv0, exp_pix);
        check({name, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk); #1;
        check({name, "_done_pulse"}, o_done, 0);
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_x0 = '0; i_y0 = '0; i_x1 = '0; i_y1 = '0; i_x2 = '0; i_y2 = '0;
        i_z = '0; i_color = '0;
        pix.i_display_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        check("reset_valid", pix.o_pixel_write_valid, 0);
        check("reset_addr", pix.o_pixel_write_addr, 0);
        check("reset_fb", pix.o_fb_data, 0);
        check("reset_db", pix.o_db_data, 0);
        rst = 1'b0;

        run_tri("tri_a",       0,   0,   4,   0,   0,   4, 1, 0,   4,   0,   4,   4,    25,    15, 0, 0);
        run_tri("tri_b",       0,   0,   0,   4,   4,   0, 0, 0,   4,   0,   4,   4,    25,    15, 0, 0);
        run_tri("tri_b_stall", 0,   0,   0,   4,   4,   0, 0, 0,   4,   0,   4,   4,    25,    15, 5, 0);
        run_tri("tri_c",       1,   1,   3,   1,   1,   3, 1, 1,   3,   1,   3,   4,     9,     6, 0, 0);
        run_tri("edge_clip", 150, 110, 170, 110, 150, 130, 1, 150, 159, 110, 119, 280,  100,   100, 0, 0);
        run_tri("offscreen", -20, -20,  -5, -20, -20,  -5, 1, 0,   0,   0,   0,   0,     0,     0, 0, 0);
        run_tri("collinear",   0,   0,   5,   5,  10,  10, 0, 0,   0,   0,   0,   0,     0,     0, 0, 0);
        run_tri("full_clip", -10, -10, 200, -10, -10, 200, 1, 0, 159,   0, 119, 190, 19200, 15284, 0, 0);

        run_id++;
        cur_color = 4'(run_id + 2);
        cur_z     = 12'(run_id * 211 + 7);
        push_expect(0, 159, 0, 119, 190);
        start_tri(-10, -10, -10, 200, 200, -10);
        repeat (40) @(posedge clk);
        #1;
        check("rst_pre_valid", pix.o_pixel_write_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_valid", pix.o_pixel_write_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_addr", pix.o_pixel_write_addr, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_tri("tri_c_post",  1,   1,   3,   1,   1,   3, 1, 1,   3,   1,   3,   4,     9,     6, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
